mod_updown_counter: RTL and testbench
=====================================

// Module: mod_updown_counter
// PURPOSE
//  Parametrised modulo-N up/down counter: generalised width and modulus, runtime direction,
//  synchronous load/clear, count enable and wrap-or-saturate mode.
//  Emits a terminal-count strobe for cascading (tc of stage k drives en of stage k+1).
//  Used as the common timebase/divider primitive across the design.
// PARAMETERS
//  WIDTH    3  count width in bits; 1..32
//  MODULUS  5  count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH (elaboration error otherwise)
//  RST_VAL  0  count value after reset and clr; must be < MODULUS
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous active-low reset
//  clr       in   1      synchronous clear to RST_VAL
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  value for load
//  en        in   1      count enable
//  up        in   1      1 = count up, 0 = count down
//  sat       in   1      1 = saturate at end of range, 0 = wrap modulo MODULUS
//  count     out  WIDTH  current count, registered
//  tc        out  1      combinational terminal count:
//                        en & ((up & count==MODULUS-1) | (!up & count==0))
//  wrapped   out  1      registered one-cycle pulse: a wrap occurred on the previous edge
//  sat_hit   out  1      registered level: count is held at a limit in sat mode
//  load_err  out  1      sticky flag: load attempted with load_val >= MODULUS
// BEHAVIOUR
//  Reset (rst=0, async, no clk needed):
//   - count=RST_VAL; wrapped=0; sat_hit=0; load_err=0.
//   - Release is synchronised by the user; first counting edge is the first rising clk with rst=1.
//  Per-edge priority is clr > load > en; with none asserted, count holds.
//  clr:
//   - count<=RST_VAL; load_err<=0; wrapped<=0; sat_hit<=0.
//  load:
//   - load_val < MODULUS: count<=load_val, wrapped<=0.
//   - load_val >= MODULUS: count holds, load_err<=1 (sticky until clr or reset).
//   - load overrides en in the same cycle; no count step is taken.
//  Counting (en=1):
//   - up=1:  count<MODULUS-1 -> count+1.
//            count==MODULUS-1 -> 0 with wrapped<=1 when sat=0; hold with sat_hit<=1 when sat=1.
//   - up=0:  count>0 -> count-1.
//            count==0 -> MODULUS-1 with wrapped<=1 when sat=0; hold with sat_hit<=1 when sat=1.
//   - Arithmetic is carried in WIDTH+1 bits internally.
//     MODULUS=2**WIDTH must wrap correctly with no truncation glitch.
//  Flag updates:
//   - wrapped is 0 on every edge that does not wrap (a pure pulse).
//   - sat_hit clears on any edge where count moves, or where sat=0.
//  Direction and mode:
//   - up and sat are sampled every edge; changing direction mid-count takes effect on that edge,
//     with no extra latency or dead cycle.
//  Latency and cascading:
//   - count changes 1 cycle after en/load/clr are sampled.
//   - tc is valid in the same cycle as count and en, so cascaded stages step on the same edge as the wrap.
//  Out-of-range state (count >= MODULUS, unreachable except by fault):
//   - Next enabled step forces count<=0 (up) or MODULUS-1 (down); no wrapped pulse.
//  Reset mid-operation:
//   - Asynchronous assertion overrides all inputs immediately; outputs take their reset values with no clock.
// TESTING
//  1. Default params, rst pulse low mid-count (count=3), no clk edge
//     -> count=0 and all flags 0 immediately.
//  2. en=1, up=1, sat=0, 12 edges from 0
//     -> 1,2,3,4,0,1,2,3,4,0,1,2; wrapped high exactly the cycles after 4->0;
//        tc high while count==4.
//  3. en=1, up=0, sat=1, load_val=2 then load
//     -> 2,1,0,0,0; sat_hit=1 from the second 0; switch up=1 -> 1 and sat_hit=0.
//  4. load_val=6 (>=MODULUS) with load=1 at count=2
//     -> count stays 2, load_err=1; stays set through counting; clr -> count=0, load_err=0.
//  5. Simultaneous clr+load+en at count=3 -> count=0;
//     load+en with load_val=1 -> count=1 (no step taken).
//  6. WIDTH=4, MODULUS=16, two cascaded instances (tc0->en1), up, 300 edges
//     -> {count1,count0} increments by 1 per edge and wraps 255->0;
//     plus a direction toggle every 7 edges in single-instance mode, checked against a reference model.

Source files
------------

// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The master drives the controls; the counter observes them and drives status.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = 3
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic             sat;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrapped;
  logic             sat_hit;
  logic             load_err;

  modport master (
    output clr, load, load_val, en, up, sat,
    input  count, tc, wrapped, sat_hit, load_err
  );

  modport slave (
    input  clr, load, load_val, en, up, sat,
    output count, tc, wrapped, sat_hit, load_err
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, clear, saturate mode and a
// combinational terminal-count strobe for cascading stages.
module mod_updown_counter #(
  parameter int unsigned     WIDTH   = 3,
  parameter longint unsigned MODULUS = 5,
  parameter longint unsigned RST_VAL = 0
) (
  input logic                 clk,
  input logic                 rst,
  mod_updown_counter_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
      MODULUS > (64'd1 << WIDTH) || RST_VAL >= MODULUS) begin : g_bad
    $error("mod_updown_counter: illegal WIDTH/MODULUS/RST_VAL");
  end

  // One spare bit so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0] MOD  = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0] TOP  = MOD - 1'b1;
  localparam logic [WIDTH:0] RSTX = RST_VAL[WIDTH:0];

  logic [WIDTH:0] count_q;
  logic           wrapped_q;
  logic           sat_q;
  logic           err_q;

  logic [WIDTH:0] lvx;
  logic [WIDTH:0] nx;
  logic           nwrap;
  logic           nsat;
  logic           nerr;
  logic           hold_hit;

  assign lvx = {1'b0, bus.load_val};

  // Next-state: clr beats load beats en.
  always_comb begin
    nx       = count_q;
    nwrap    = 1'b0;
    nsat     = sat_q & bus.sat;
    nerr     = err_q;
    hold_hit = 1'b0;
    if (bus.clr) begin
      nx   = RSTX;
      nsat = 1'b0;
      nerr = 1'b0;
    end else if (bus.load) begin
      if (lvx < MOD) nx = lvx;
      else           nerr = 1'b1;
    end else if (bus.en) begin
      if (bus.up) begin
        if (count_q >= MOD) begin
          nx = '0;
        end else if (count_q == TOP) begin
          if (bus.sat) hold_hit = 1'b1;
          else begin
            nx    = '0;
            nwrap = 1'b1;
          end
        end else begin
          nx = count_q + 1'b1;
        end
      end else begin
        if (count_q >= MOD) begin
          nx = TOP;
        end else if (count_q == '0) begin
          if (bus.sat) hold_hit = 1'b1;
          else begin
            nx    = TOP;
            nwrap = 1'b1;
          end
        end else begin
          nx = count_q - 1'b1;
        end
      end
    end
    if (nx != count_q) nsat = 1'b0;
    if (hold_hit)      nsat = 1'b1;
  end

  // Count and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= RSTX;
      wrapped_q <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= nx;
      wrapped_q <= nwrap;
      sat_q     <= nsat;
      err_q     <= nerr;
    end
  end

  assign bus.count    = count_q[WIDTH-1:0];
  assign bus.wrapped  = wrapped_q;
  assign bus.sat_hit  = sat_q;
  assign bus.load_err = err_q;
  assign bus.tc       = bus.en &
                        (( bus.up & (count_q == TOP)) |
                         (!bus.up & (count_q == '0)));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench: directed vector table, async reset, random
// stimulus against a reference model, and a two-stage cascade.
module tb_mod_updown_counter;
  localparam int M = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(3)) b ();
  mod_updown_counter_if #(.WIDTH(4)) c0 ();
  mod_updown_counter_if #(.WIDTH(4)) c1 ();

  assign c1.en = c0.tc;

  mod_updown_counter #(.WIDTH(3), .MODULUS(5), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) st0 (
    .clk(clk), .rst(rst), .bus(c0)
  );
  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) st1 (
    .clk(clk), .rst(rst), .bus(c1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       clr;
    logic       load;
    logic [2:0] lv;
    logic       en;
    logic       up;
    logic       sat;
    int         c;
    logic       w;
    logic       s;
    logic       e;
    logic       t;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic cl, input logic ld, input int lv,
                     input logic en, input logic up, input logic sa,
                     input int c, input logic w, input logic s,
                     input logic e, input logic t);
    vec_t v;
    v = '{cl, ld, lv[2:0], en, up, sa, c, w, s, e, t};
    tbl.push_back(v);
  endtask

  // Reference model state
  int   m_c;
  logic m_w, m_s, m_e;

  function automatic logic m_tc(input logic en, input logic up);
    return en && ((up && m_c == M - 1) || (!up && m_c == 0));
  endfunction

  task automatic model_step(input logic cl, input logic ld, input int lv,
                            input logic en, input logic up, input logic sa);
    int   old;
    logic old_s;
    logic at_end;
    logic hit;
    old   = m_c;
    old_s = m_s;
    hit   = 1'b0;
    m_w   = 1'b0;
    if (cl) begin
      m_c = 0;
      m_e = 1'b0;
    end else if (ld) begin
      if (lv < M) m_c = lv;
      else        m_e = 1'b1;
    end else if (en) begin
      at_end = up ? (old == M - 1) : (old == 0);
      if (at_end && sa) hit = 1'b1;
      else begin
        m_c = up ? (old + 1) % M : (old + M - 1) % M;
        m_w = at_end;
      end
    end
    m_s = hit | (!cl && old_s && sa && (m_c == old));
  endtask

  task automatic drive(input logic cl, input logic ld, input int lv,
                       input logic en, input logic up, input logic sa);
    b.clr      = cl;
    b.load     = ld;
    b.load_val = lv[2:0];
    b.en       = en;
    b.up       = up;
    b.sat      = sa;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_edge(input string nm, input logic cl, input logic ld,
                           input int lv, input logic en, input logic up,
                           input logic sa);
    drive(cl, ld, lv, en, up, sa);
    #1;
    chk({nm, "_tc"}, b.tc, m_tc(en, up));
    tick();
    model_step(cl, ld, lv, en, up, sa);
    chk({nm, "_count"}, b.count, m_c);
    chk({nm, "_wrapped"}, b.wrapped, m_w);
    chk({nm, "_sat_hit"}, b.sat_hit, m_s);
    chk({nm, "_load_err"}, b.load_err, m_e);
  endtask

  initial begin
    logic up_dir;
    int   exp;
    drive(0, 0, 0, 0, 0, 0);
    c0.clr = 0; c0.load = 0; c0.load_val = '0;
    c0.en = 0; c0.up = 1; c0.sat = 0;
    c1.clr = 0; c1.load = 0; c1.load_val = '0;
    c1.up = 1; c1.sat = 0;

    // Directed table, starting from reset (count 0)
    for (int i = 1; i <= 12; i++) begin
      add(0, 0, 0, 1, 1, 0, i % 5, (i % 5) == 0, 0, 0,
          ((i - 1) % 5) == 4);
    end
    add(0, 1, 6, 0, 1, 0, 2, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0, 3, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0, 4, 0, 0, 1, 0);
    add(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 3, 0, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 2, 1, 0, 1, 2, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);

    tick();
    tick();
    chk("rst_count", b.count, 0);
    chk("rst_wrapped", b.wrapped, 0);
    chk("rst_sat_hit", b.sat_hit, 0);
    chk("rst_load_err", b.load_err, 0);
    chk("rst_casc", {c1.count, c0.count}, 0);
    rst = 1'b1;
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].load, int'(tbl[i].lv),
            tbl[i].en, tbl[i].up, tbl[i].sat);
      #1;
      chk($sformatf("vec%0d_tc", i), b.tc, tbl[i].t);
      tick();
      chk($sformatf("vec%0d_count", i), b.count, tbl[i].c);
      chk($sformatf("vec%0d_wrapped", i), b.wrapped, tbl[i].w);
      chk($sformatf("vec%0d_sat_hit", i), b.sat_hit, tbl[i].s);
      chk($sformatf("vec%0d_load_err", i), b.load_err, tbl[i].e);
    end

    // Async reset mid-count with load_err set, no clock edge
    drive(0, 1, 3, 0, 1, 0);
    tick();
    drive(0, 1, 7, 1, 1, 0);
    tick();
    chk("pre_arst_count", b.count, 3);
    chk("pre_arst_err", b.load_err, 1);
    drive(0, 0, 0, 0, 1, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_count", b.count, 0);
    chk("arst_err", b.load_err, 0);
    chk("arst_wrapped", b.wrapped, 0);
    chk("arst_sat_hit", b.sat_hit, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    m_c = 0; m_w = 0; m_s = 0; m_e = 0;

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      rand_edge("rnd",
                ($urandom % 32) == 0,
                ($urandom % 8) == 0,
                int'($urandom % 8),
                ($urandom % 4) != 0,
                $urandom % 2,
                ($urandom % 3) == 0);
    end

    // Direction toggle every 7 edges
    up_dir = 1'b1;
    for (int i = 0; i < 140; i++) begin
      if (i % 7 == 0 && i != 0) up_dir = ~up_dir;
      rand_edge("dir", 0, 0, 0, 1, up_dir, ($urandom % 4) == 0);
    end

    // Cascade: {count1,count0} is an 8-bit up counter
    c0.en = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      exp = k % 256;
      chk($sformatf("casc%0d", k), {c1.count, c0.count}, exp);
      if (k % 256 == 0) chk("casc_wrap1", c1.wrapped, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
